// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter_if                                                    |
// | Writeback request, reservation, hazard-query and register-file bundle.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                     wb0_valid;
  logic                     wb0_ready;
  logic [ADDR_W-1:0]        wb0_addr;
  logic [DATA_W-1:0]        wb0_data;
  logic                     wb1_valid;
  logic                     wb1_ready;
  logic [ADDR_W-1:0]        wb1_addr;
  logic [DATA_W-1:0]        wb1_data;
  logic                     rsv_valid;
  logic                     rsv_ready;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [ADDR_W-1:0]        rs_addr;
  logic [ADDR_W-1:0]        rt_addr;
  logic                     rs_busy;
  logic                     rt_busy;
  logic                     rf_we;
  logic [ADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]        rf_wdata;
  logic [(1<<ADDR_W)-1:0]   busy_vec;

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    input  rsv_valid, rsv_addr, rs_addr, rt_addr,
    output wb0_ready, wb1_ready, rsv_ready, rs_busy, rt_busy,
    output rf_we, rf_waddr, rf_wdata, busy_vec
  );

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    output rsv_valid, rsv_addr, rs_addr, rt_addr,
    input  wb0_ready, wb1_ready, rsv_ready, rs_busy, rt_busy,
    input  rf_we, rf_waddr, rf_wdata, busy_vec
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter                                                       |
// | Two-port writeback arbiter with registered RF write and busy scoreboard. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIXED_PRIO = 0
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  logic              pref_q, pref_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              w_gnt0, w_gnt1, w_rsv_acc;
  logic [NREG-1:0]   w_set, w_clr;

  // pref_q: 0 prefers port 0, 1 prefers port 1 (ignored in fixed mode)
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset_n) begin
      w_gnt0 = bus.wb0_valid && (!bus.wb1_valid || (FIXED_PRIO != 0) || !pref_q);
      w_gnt1 = bus.wb1_valid && !w_gnt0;
    end
    w_rsv_acc = reset_n && bus.rsv_valid && !busy_q[bus.rsv_addr];
  end

  always_comb begin
    pref_d  = pref_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (w_gnt0) begin
      pref_d  = 1'b1;
      we_d    = (bus.wb0_addr != '0);
      waddr_d = bus.wb0_addr;
      wdata_d = bus.wb0_data;
    end else if (w_gnt1) begin
      pref_d  = 1'b0;
      we_d    = (bus.wb1_addr != '0);
      waddr_d = bus.wb1_addr;
      wdata_d = bus.wb1_data;
    end
  end

  // Clear lands at the end of the rf_we cycle; a same-edge set overrides it
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_rsv_acc && (bus.rsv_addr != '0)) w_set[bus.rsv_addr] = 1'b1;
    if (we_q) w_clr[waddr_q] = 1'b1;
    busy_d    = (busy_q & ~w_clr) | w_set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pref_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      pref_q  <= pref_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.wb0_ready = w_gnt0;
  assign bus.wb1_ready = w_gnt1;
  assign bus.rsv_ready = reset_n && !busy_q[bus.rsv_addr];
  assign bus.rs_busy   = (bus.rs_addr != '0) && busy_q[bus.rs_addr];
  assign bus.rt_busy   = (bus.rt_addr != '0) && busy_q[bus.rt_addr];
  assign bus.rf_we     = we_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.busy_vec  = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter                                                    |
// | Directed bench: round-robin instance plus a fixed-priority instance.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) r_if ();
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) f_if ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset_n(reset_n), .bus(r_if)
  );
  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset_n(reset_n), .bus(f_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    r_if.wb0_valid = 1'b1; r_if.wb0_addr = 5'd4; r_if.wb0_data = 32'h4;
    r_if.wb1_valid = 1'b0; r_if.wb1_addr = 5'd0; r_if.wb1_data = 32'h0;
    r_if.rsv_valid = 1'b0; r_if.rsv_addr = 5'd0;
    r_if.rs_addr = 5'd0;   r_if.rt_addr = 5'd0;
    f_if.wb0_valid = 1'b0; f_if.wb0_addr = 5'd0; f_if.wb0_data = 32'h0;
    f_if.wb1_valid = 1'b0; f_if.wb1_addr = 5'd0; f_if.wb1_data = 32'h0;
    f_if.rsv_valid = 1'b0; f_if.rsv_addr = 5'd0;
    f_if.rs_addr = 5'd0;   f_if.rt_addr = 5'd0;

    // Reset state
    cyc();
    chk("rst_we",      32'(r_if.rf_we), 0);
    chk("rst_waddr",   32'(r_if.rf_waddr), 0);
    chk("rst_wdata",   r_if.rf_wdata, 0);
    chk("rst_busy",    r_if.busy_vec, 0);
    chk("rst_wb0_rdy", 32'(r_if.wb0_ready), 0);
    chk("rst_rsv_rdy", 32'(r_if.rsv_ready), 0);
    r_if.wb0_valid = 1'b0;
    reset_n = 1'b1;
    cyc();

    // Reserve r9, write r9, then reset while rf_we is high
    r_if.rsv_valid = 1'b1; r_if.rsv_addr = 5'd9;
    #1 chk("r9_rsv_rdy", 32'(r_if.rsv_ready), 1);
    cyc();
    r_if.rsv_valid = 1'b0;
    chk("r9_busy", r_if.busy_vec, 32'h0000_0200);
    r_if.wb0_valid = 1'b1; r_if.wb0_addr = 5'd9; r_if.wb0_data = 32'h99;
    #1 chk("r9_wb0_rdy", 32'(r_if.wb0_ready), 1);
    cyc();
    r_if.wb0_valid = 1'b0;
    chk("r9_we", 32'(r_if.rf_we), 1);
    chk("r9_busy_we", r_if.busy_vec, 32'h0000_0200);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_we",   32'(r_if.rf_we), 0);
    chk("mid_rst_busy", r_if.busy_vec, 0);
    #1 reset_n = 1'b1;
    r_if.wb0_valid = 1'b1; r_if.wb0_addr = 5'd3; r_if.wb0_data = 32'h11;
    cyc();
    r_if.wb0_valid = 1'b0;
    chk("r3_we",    32'(r_if.rf_we), 1);
    chk("r3_waddr", 32'(r_if.rf_waddr), 3);
    chk("r3_wdata", r_if.rf_wdata, 32'h11);
    cyc();
    chk("r3_we_drop", 32'(r_if.rf_we), 0);

    // Zero register: accepted, no write strobe, no reservation bit
    r_if.wb1_valid = 1'b1; r_if.wb1_addr = 5'd0; r_if.wb1_data = 32'hFFFF_FFFF;
    #1 chk("r0_wb1_rdy", 32'(r_if.wb1_ready), 1);
    cyc();
    r_if.wb1_valid = 1'b0;
    chk("r0_we",    32'(r_if.rf_we), 0);
    chk("r0_wdata", r_if.rf_wdata, 32'hFFFF_FFFF);
    r_if.rsv_valid = 1'b1; r_if.rsv_addr = 5'd0; r_if.rs_addr = 5'd0;
    #1 chk("r0_rsv_rdy", 32'(r_if.rsv_ready), 1);
    cyc();
    r_if.rsv_valid = 1'b0;
    chk("r0_busy",    r_if.busy_vec, 0);
    chk("r0_rs_busy", 32'(r_if.rs_busy), 0);

    // Round-robin contention, port 0 preferred at this point
    r_if.wb0_valid = 1'b1; r_if.wb0_addr = 5'd5; r_if.wb0_data = 32'hAAAA;
    r_if.wb1_valid = 1'b1; r_if.wb1_addr = 5'd6; r_if.wb1_data = 32'hBBBB;
    #1;
    chk("rr0_wb0_rdy", 32'(r_if.wb0_ready), 1);
    chk("rr0_wb1_rdy", 32'(r_if.wb1_ready), 0);
    cyc();
    chk("rr1_wb0_rdy", 32'(r_if.wb0_ready), 0);
    chk("rr1_wb1_rdy", 32'(r_if.wb1_ready), 1);
    chk("rr1_we",      32'(r_if.rf_we), 1);
    chk("rr1_waddr",   32'(r_if.rf_waddr), 5);
    chk("rr1_wdata",   r_if.rf_wdata, 32'hAAAA);
    r_if.wb0_valid = 1'b0;
    cyc();
    r_if.wb1_valid = 1'b0;
    chk("rr2_we",    32'(r_if.rf_we), 1);
    chk("rr2_waddr", 32'(r_if.rf_waddr), 6);
    chk("rr2_wdata", r_if.rf_wdata, 32'hBBBB);
    cyc();
    chk("rr3_we", 32'(r_if.rf_we), 0);

    // Fixed priority: port 0 wins every cycle
    f_if.wb0_valid = 1'b1; f_if.wb0_addr = 5'd1;
    f_if.wb1_valid = 1'b1; f_if.wb1_addr = 5'd2; f_if.wb1_data = 32'h2;
    for (int i = 0; i < 3; i++) begin
      f_if.wb0_data = 32'h100 + 32'(i);
      #1;
      chk("fp_wb0_rdy", 32'(f_if.wb0_ready), 1);
      chk("fp_wb1_rdy", 32'(f_if.wb1_ready), 0);
      cyc();
      chk("fp_waddr", 32'(f_if.rf_waddr), 1);
      chk("fp_wdata", f_if.rf_wdata, 32'h100 + 32'(i));
    end
    f_if.wb0_valid = 1'b0; f_if.wb1_valid = 1'b0;

    // Scoreboard life-cycle on r8, hazard on r17
    r_if.rsv_valid = 1'b1; r_if.rsv_addr = 5'd8; r_if.rs_addr = 5'd8; r_if.rt_addr = 5'd17;
    #1 chk("r8_rs_busy_pre", 32'(r_if.rs_busy), 0);
    cyc();
    chk("r8_rs_busy", 32'(r_if.rs_busy), 1);
    chk("r8_waw_rdy", 32'(r_if.rsv_ready), 0);
    r_if.rsv_addr = 5'd17;
    cyc();
    r_if.rsv_valid = 1'b0;
    chk("r17_busy_vec", r_if.busy_vec, 32'h0002_0100);
    chk("r17_rt_busy",  32'(r_if.rt_busy), 1);
    r_if.wb0_valid = 1'b1; r_if.wb0_addr = 5'd8; r_if.wb0_data = 32'h88;
    cyc();
    r_if.wb0_valid = 1'b0;
    r_if.rsv_addr = 5'd8;
    #1;
    chk("r8_we",         32'(r_if.rf_we), 1);
    chk("r8_busy_in_we", 32'(r_if.rs_busy), 1);
    chk("r8_rsv_in_we",  32'(r_if.rsv_ready), 0);
    cyc();
    chk("r8_cleared",   32'(r_if.rs_busy), 0);
    chk("r17_still",    32'(r_if.rt_busy), 1);
    r_if.wb1_valid = 1'b1; r_if.wb1_addr = 5'd17; r_if.wb1_data = 32'h17;
    cyc();
    r_if.wb1_valid = 1'b0;
    chk("r17_we",      32'(r_if.rf_waddr), 17);
    chk("r17_busy_we", 32'(r_if.rt_busy), 1);
    cyc();
    chk("r17_cleared", 32'(r_if.rt_busy), 0);
    chk("sb_empty",    r_if.busy_vec, 0);

    // Set and clear of r8 on the same edge: set wins
    r_if.wb0_valid = 1'b1; r_if.wb0_addr = 5'd8; r_if.wb0_data = 32'h8;
    cyc();
    r_if.wb0_valid = 1'b0;
    chk("r8b_we", 32'(r_if.rf_we), 1);
    r_if.rsv_valid = 1'b1; r_if.rsv_addr = 5'd8;
    #1 chk("r8b_rsv_rdy", 32'(r_if.rsv_ready), 1);
    cyc();
    r_if.rsv_valid = 1'b0;
    chk("r8b_set_wins", r_if.busy_vec, 32'h0000_0100);
    chk("r8b_rs_busy",  32'(r_if.rs_busy), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters.
  - Port 0: ALU result path.
  - Port 1: load/memory path.
- Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the 32x32 register file. It drives the register file's regWrite, writeRegister and writeData inputs from a registered output stage.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wb0_valid  input  1  port 0 write request.
- wb0_ready  output  1  port 0 request accepted this cycle.
- wb0_addr  input  ADDR_W  port 0 destination register.
- wb0_data  input  DATA_W  port 0 write data.
- wb1_valid  input  1  port 1 write request.
- wb1_ready  output  1  port 1 request accepted this cycle.
- wb1_addr  input  ADDR_W  port 1 destination register.
- wb1_data  input  DATA_W  port 1 write data.
- rsv_valid  input  1  decode reserves a destination register.
- rsv_ready  output  1  reservation accepted.
- rsv_addr  input  ADDR_W  register to reserve.
- rs_addr  input  ADDR_W  source-register query A.
- rt_addr  input  ADDR_W  source-register query B.
- rs_busy  output  1  rs_addr has a pending write.
- rt_busy  output  1  rt_addr has a pending write.
- rf_we  output  1  register-file regWrite.
- rf_waddr  output  ADDR_W  register-file writeRegister.
- rf_wdata  output  DATA_W  register-file writeData.
- busy_vec  output  2**ADDR_W  scoreboard bitmap, for debug.

Behaviour:
- Reset: asynchronous and active-low. While reset_n=0:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - busy_vec=0.
  - Round-robin pointer = port 0 (port 0 preferred).
  - All ready outputs = 0.
  - Reset mid-operation drops any in-flight write: rf_we falls immediately and all reservations clear.
- Arbitration (combinational grant, one acceptance per cycle):
  - Only one valid: that port's ready=1.
  - Both valid, FIXED_PRIO=1: port 0 wins.
  - Both valid, FIXED_PRIO=0: the preferred port wins. After any grant, the other port becomes preferred.
  - The loser's ready=0. It must hold valid, addr and data stable until accepted.
  - No valid: pointer is unchanged.
- Write stage (latency 1):
  - On the edge where valid&&ready, register rf_waddr and rf_wdata. Set rf_we=1 for exactly that following cycle.
  - Back-to-back grants give one write per cycle.
  - Writes to register 0 are accepted (ready=1) but rf_we stays 0. rf_waddr and rf_wdata still update.
- Scoreboard:
  - busy_vec[r] is set on the edge where rsv_valid&&rsv_ready with rsv_addr=r.
  - It is cleared on the edge that ends the cycle in which rf_we=1 with rf_waddr=r.
  - The bit therefore stays set during the rf_we cycle, so readers never race the register-file write.
  - rsv_ready = !busy_vec[rsv_addr], a WAW stall.
  - rsv_addr=0: rsv_ready=1 and no bit is set.
  - Bit 0 is never set.
  - Same edge sets and clears the same register: set wins, bit stays 1.
  - A write to an unreserved register is legal; its clear is a no-op.
- Queries:
  - rs_busy = busy_vec[rs_addr] and rt_busy = busy_vec[rt_addr], combinational.
  - Address 0 always returns 0.

Test Plan:
- Reset mid-write: with rf_we=1 and busy_vec[9]=1, pulse reset_n low between edges -> rf_we=0 and busy_vec=0 immediately; after release, a wb0 write to r3 of 0x11 gives rf_we=1 one cycle later with rf_waddr=3, rf_wdata=0x11.
- Round-robin contention: wb0 targets r5/0xAAAA and wb1 targets r6/0xBBBB, both held valid, FIXED_PRIO=0 -> cycle 0 grants wb0, cycle 1 grants wb1; writes appear on consecutive cycles, r5 then r6.
- Fixed priority: FIXED_PRIO=1, both ports valid for 3 cycles -> wb1_ready=0 throughout and wb0 is accepted every cycle.
- Zero register: wb1 writes r0 with 0xFFFF_FFFF -> wb1_ready=1 and rf_we stays 0; a reservation of r0 sets no bit and rs_busy=0 with rs_addr=0.
- Scoreboard life-cycle: reserve r8 -> rs_busy=1 next cycle; a second reserve of r8 sees rsv_ready=0; wb0 writes r8 -> bit stays 1 through the rf_we cycle, then reads 0; reserving r8 on that clearing edge leaves the bit 1.
- Hazard stall: rt_addr=17 while r17 is reserved -> rt_busy=1 until the cycle after the r17 write commits.
